// File: rtl/phase_seq_pkg.sv
// ============================================================================
// Module : phase_seq_pkg
// Brief  : Phase codes, monitor state type and successor function shared by
//          the phase sequence monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package phase_seq_pkg;

  localparam logic [1:0] PH_A   = 2'b01;
  localparam logic [1:0] PH_B   = 2'b11;
  localparam logic [1:0] PH_C   = 2'b10;
  localparam logic [1:0] PH_ILL = 2'b00;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

  // Illegal input maps to PH_ILL so it can never match a real code.
  function automatic logic [1:0] succ(input logic [1:0] code);
    case (code)
      PH_A:    succ = PH_B;
      PH_B:    succ = PH_C;
      PH_C:    succ = PH_A;
      default: succ = PH_ILL;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/phase_seq_monitor_sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Saturating up-counter; clr takes effect before a same-cycle inc.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] C_MAX = {W{1'b1}};

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= i_inc ? W'(1) : '0;
    end else if (i_inc && (r_count != C_MAX)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/phase_seq_monitor.sv
// ============================================================================
// Module : phase_seq_monitor
// Brief  : Locks onto the 01->11->10 phase code stream, flags out-of-order and
//          illegal codes while locked, and counts rounds and errors.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module phase_seq_monitor
  import phase_seq_pkg::*;
#(
  parameter int SYNC_LEN = 3,
  parameter int LOSS_LEN = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       in_code,
  input  logic             in_valid,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] round_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int MW = $clog2(SYNC_LEN + 1);
  localparam int LW = $clog2(LOSS_LEN + 1);

  mon_state_t    r_state, w_state_nxt;
  logic [1:0]    r_prev, w_prev_nxt;
  logic [MW-1:0] r_match, w_match_nxt, w_match_inc;
  logic [LW-1:0] r_miss, w_miss_nxt, w_miss_inc;
  logic          r_err_pulse, r_err_sticky;
  logic          w_err, w_round, w_good;
  logic [1:0]    w_succ;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= HUNT;
      r_prev       <= PH_ILL;
      r_match      <= '0;
      r_miss       <= '0;
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev       <= w_prev_nxt;
      r_match      <= w_match_nxt;
      r_miss       <= w_miss_nxt;
      r_err_pulse  <= w_err;
      r_err_sticky <= clr ? w_err : (r_err_sticky | w_err);
    end
  end

  assign w_succ      = succ(r_prev);
  assign w_good      = (in_code == w_succ);
  assign w_match_inc = r_match + MW'(1);
  assign w_miss_inc  = r_miss + LW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_match_nxt = r_match;
    w_miss_nxt  = r_miss;
    w_err       = 1'b0;
    w_round     = 1'b0;
    if (in_valid) begin
      case (r_state)
        HUNT: begin
          if (in_code != PH_ILL) begin
            w_prev_nxt  = in_code;
            w_match_nxt = '0;
            w_state_nxt = SYNC;
          end
        end
        SYNC: begin
          if (in_code == PH_ILL) begin
            w_state_nxt = HUNT;
          end else if (w_good) begin
            w_prev_nxt  = in_code;
            w_match_nxt = w_match_inc;
            if (w_match_inc == MW'(SYNC_LEN)) begin
              w_state_nxt = LOCKED;
              w_miss_nxt  = '0;
            end
          end else begin
            w_prev_nxt  = in_code;
            w_match_nxt = '0;
          end
        end
        LOCKED: begin
          // Flywheel: expected phase advances regardless of what arrived.
          w_prev_nxt = w_succ;
          if (w_good) begin
            w_miss_nxt = '0;
            w_round    = (in_code == PH_C);
          end else begin
            w_err      = 1'b1;
            w_miss_nxt = w_miss_inc;
            if (w_miss_inc == LW'(LOSS_LEN)) begin
              w_state_nxt = HUNT;
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_round_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_round),
    .i_clr   (clr),
    .o_count (round_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_err),
    .i_clr   (clr),
    .o_count (err_cnt)
  );

  assign locked     = (r_state == LOCKED);
  assign err_pulse  = r_err_pulse;
  assign err_sticky = r_err_sticky;

endmodule

`default_nettype wire

// File: tb/tb_phase_seq_monitor.sv
// ============================================================================
// Module : tb_phase_seq_monitor
// Brief  : Directed self-checking bench for phase_seq_monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_phase_seq_monitor;

  logic       clk;
  logic       rst;
  logic [1:0] in_code;
  logic       in_valid;
  logic       clr;
  logic       locked;
  logic       err_pulse;
  logic       err_sticky;
  logic [7:0] round_cnt;
  logic [7:0] err_cnt;

  int r_checks = 0;
  int r_errors = 0;

  phase_seq_monitor #(.SYNC_LEN(3), .LOSS_LEN(2), .CNT_W(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_code    (in_code),
    .in_valid   (in_valid),
    .clr        (clr),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .round_cnt  (round_cnt),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    r_checks++;
    if (got !== exp) begin
      r_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one sample at the falling edge; return just after the rising edge.
  task automatic step(input logic [1:0] code, input logic v, input logic c, input logic r);
    @(negedge clk);
    in_code  = code;
    in_valid = v;
    clr      = c;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic l, input logic p, input logic s,
                           input logic [7:0] rc, input logic [7:0] ec);
    check({tag, ".locked"},     32'(locked),     32'(l));
    check({tag, ".err_pulse"},  32'(err_pulse),  32'(p));
    check({tag, ".err_sticky"}, 32'(err_sticky), 32'(s));
    check({tag, ".round_cnt"},  32'(round_cnt),  32'(rc));
    check({tag, ".err_cnt"},    32'(err_cnt),    32'(ec));
  endtask

  initial begin
    in_code  = 2'b00;
    in_valid = 1'b0;
    clr      = 1'b0;
    rst      = 1'b1;

    // Reset
    step(2'b00, 1'b0, 1'b0, 1'b1);
    step(2'b01, 1'b1, 1'b0, 1'b1);
    check_all("reset", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

    // 1: acquisition, lock after 4th sample, rounds counted only while locked
    step(2'b01, 1'b1, 1'b0, 1'b0);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b0, 1'b0);
    check("acq3.locked", 32'(locked), 32'd0);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    check_all("acq4", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b0, 1'b0);
    check("round1", 32'(round_cnt), 32'd1);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b0, 1'b0);
    check_all("round2", 1'b1, 1'b0, 1'b0, 8'd2, 8'd0);

    // 2: single out-of-order code keeps lock
    step(2'b01, 1'b1, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    check_all("ooo", 1'b1, 1'b1, 1'b1, 8'd2, 8'd1);
    step(2'b10, 1'b1, 1'b0, 1'b0);
    check_all("ooo_resume", 1'b1, 1'b0, 1'b1, 8'd3, 8'd1);

    // 3: two consecutive illegal codes drop lock
    step(2'b00, 1'b1, 1'b0, 1'b0);
    check_all("ill1", 1'b1, 1'b1, 1'b1, 8'd3, 8'd2);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    check_all("ill2", 1'b0, 1'b1, 1'b1, 8'd3, 8'd3);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    check_all("hunt_ill", 1'b0, 1'b0, 1'b1, 8'd3, 8'd3);

    // Relock
    step(2'b01, 1'b1, 1'b0, 1'b0);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    check_all("relock", 1'b1, 1'b0, 1'b1, 8'd3, 8'd3);

    // 4: valid low holds everything
    for (int i = 0; i < 10; i++) step(2'b00, 1'b0, 1'b0, 1'b0);
    check_all("idle", 1'b1, 1'b0, 1'b1, 8'd3, 8'd3);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b0, 1'b0);
    check_all("idle_resume", 1'b1, 1'b0, 1'b1, 8'd4, 8'd3);

    // 5: saturation, then clear with simultaneous events
    for (int i = 0; i < 251; i++) begin
      step(2'b01, 1'b1, 1'b0, 1'b0);
      step(2'b11, 1'b1, 1'b0, 1'b0);
      step(2'b10, 1'b1, 1'b0, 1'b0);
    end
    check("sat255", 32'(round_cnt), 32'd255);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b0, 1'b0);
    check_all("sat_hold", 1'b1, 1'b0, 1'b1, 8'd255, 8'd3);
    step(2'b00, 1'b1, 1'b1, 1'b0);
    check_all("clr_err", 1'b1, 1'b1, 1'b1, 8'd0, 8'd1);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b1, 1'b0);
    check_all("clr_round", 1'b1, 1'b0, 1'b0, 8'd1, 8'd0);

    // 6: reset mid-lock with valid traffic
    step(2'b01, 1'b1, 1'b0, 1'b1);
    check_all("rst_mid", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b0, 1'b0);
    check("rst_hunt.locked", 32'(locked), 32'd0);
    check("rst_hunt.round_cnt", 32'(round_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
    $finish;
  end

endmodule

`default_nettype wire
